lidar_packet_ctrl: RTL and testbench
====================================

Name: lidar_packet_ctrl

Overview:
Framing and hand-off controller for the 376-bit LiDAR receive shift register. It watches the per-bit latch tick and the registered header-match flag, then locks onto the 376-bit packet cadence. On each valid packet boundary it pulses a capture strobe so a holding register can freeze the packet. It then presents the packet to the downstream consumer through a valid/ready handshake and counts dropped packets and sync losses.

Parameters:
PKT_BITS, 376, bits per LiDAR packet (ticks between consecutive packet boundaries)
TIMEOUT_CLKS, 4096, clk cycles without bit_tick before lock is declared lost
CNT_W, 9, width of bit counter (must hold PKT_BITS-1)
STAT_W, 8, width of drop/sync-loss counters

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
bit_tick  in  1  one-clk pulse per received bit (same event that shifts the shift register)
hdr_match  in  1  shift register top 16 bits == 16'h542c; valid from the clk after bit_tick
pkt_ready  in  1  consumer ready to accept held packet
capture  out  1  one-clk strobe: load holding register from shift register data_out
pkt_valid  out  1  holding register contains an unconsumed packet
locked  out  1  controller is tracking packet cadence
overrun  out  1  one-clk pulse: packet boundary dropped because holding register was busy
drop_count  out  STAT_W  saturating count of dropped packets
sync_loss_count  out  STAT_W  saturating count of lock losses (missing header or timeout)
bit_cnt  out  CNT_W  ticks since last packet boundary (0 in HUNT)

Behaviour:
- Reset (synchronous, takes effect at the clk edge while high): state=HUNT. capture, pkt_valid, locked, overrun=0. drop_count, sync_loss_count, bit_cnt, idle counter=0. Reset overrides all other events, including a pending pkt_valid.
- eval = bit_tick registered one clk. All hdr_match decisions happen only on eval cycles.
- bit_tick spacing of at least 3 clks is required. Closer spacing is out of contract.
- States:
  - HUNT: locked=0. On eval && hdr_match, a packet boundary occurs; go LOCKED, bit_cnt←0.
  - LOCKED: locked=1. On each eval with bit_cnt < PKT_BITS-1: bit_cnt++, and hdr_match is ignored (false header inside payload).
  - LOCKED, eval with bit_cnt == PKT_BITS-1: if hdr_match, a packet boundary occurs and bit_cnt←0, staying in LOCKED. Otherwise sync_loss_count++ (saturating), go HUNT, bit_cnt←0.
- Packet boundary at cycle N:
  - If pkt_valid==0, or pkt_valid&&pkt_ready in cycle N: capture=1 in N+1 and pkt_valid=1 from N+1.
  - If pkt_valid&&pkt_ready coincide with the boundary, the old packet transfers in N, and pkt_valid stays 1 continuously with the new capture in N+1.
  - If pkt_valid&&!pkt_ready: no capture, overrun=1 in N+1, drop_count++ (saturating), held packet unchanged, lock unaffected.
- Handshake:
  - Transfer occurs on any cycle with pkt_valid&&pkt_ready.
  - Without a coincident boundary, pkt_valid=0 from the next cycle.
  - pkt_valid never drops without a transfer or reset.
- Timeout:
  - The idle counter clears on bit_tick and otherwise increments, saturating at TIMEOUT_CLKS.
  - Reaching TIMEOUT_CLKS in LOCKED: go HUNT, bit_cnt←0, sync_loss_count++ (once per timeout event).
  - No effect in HUNT.
  - The handshake and held packet are unaffected by a lock loss.
- Simultaneous timeout and eval cannot occur, because the idle counter clears on bit_tick.
- Counters saturate at all-ones and do not wrap. Only reset clears them.
- All outputs are registered.

Test Plan:
- Reset, hdr_match on eval #1: locked=1 and capture pulse at eval+1. hdr_match again on eval #377 with pkt_ready=1: second capture, bit_cnt returns to 0, drop_count=0.
- Locked, hdr_match low on eval #377 after boundary: locked=0, sync_loss_count=1, no capture, bit_cnt=0.
- Locked, spurious hdr_match at bit_cnt=100: ignored, still locked. Next boundary at bit_cnt=375 captured normally.
- pkt_ready held 0 across two boundaries: one capture, pkt_valid stays 1, overrun pulses once, drop_count=1. Raising pkt_ready then clears pkt_valid next cycle.
- pkt_ready asserted exactly on boundary cycle with pkt_valid=1: capture next cycle, pkt_valid never deasserts, drop_count=0.
- Locked, stop bit_tick for 4096 clks: locked=0, sync_loss_count+1. Assert reset mid-packet with pkt_valid=1: all outputs and counters 0 on the following cycle.

Source files
------------

// File: rtl/lidar_packet_ctrl.sv
// LiDAR packet framing controller: locks onto the 376-bit packet cadence,
// strobes capture of each packet and hands it off over valid/ready.
module lidar_packet_ctrl #(
   parameter int PKT_BITS     = 376,
   parameter int TIMEOUT_CLKS = 4096,
   parameter int CNT_W        = 9,
   parameter int STAT_W       = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              bit_tick,
   input  logic              hdr_match,
   input  logic              pkt_ready,
   output logic              capture,
   output logic              pkt_valid,
   output logic              locked,
   output logic              overrun,
   output logic [STAT_W-1:0] drop_count,
   output logic [STAT_W-1:0] sync_loss_count,
   output logic [CNT_W-1:0]  bit_cnt
);

   localparam int IDLE_W = $clog2(TIMEOUT_CLKS + 1);

   typedef enum logic {
      S_HUNT   = 1'b0,
      S_LOCKED = 1'b1
   } state_t;

   state_t            r_state;
   logic              r_eval;
   logic              r_capture;
   logic              r_valid;
   logic              r_overrun;
   logic [STAT_W-1:0] r_drop;
   logic [STAT_W-1:0] r_sync;
   logic [CNT_W-1:0]  r_bit_cnt;
   logic [IDLE_W-1:0] r_idle;

   logic w_last;
   logic w_bnd;
   logic w_xfer;
   logic w_timeout;

   assign w_last    = (r_bit_cnt == CNT_W'(PKT_BITS - 1));
   assign w_xfer    = r_valid && pkt_ready;
   assign w_timeout = (r_state == S_LOCKED) &&
                      (r_idle == IDLE_W'(TIMEOUT_CLKS));

   // A header only counts in HUNT or exactly at the expected packet edge
   assign w_bnd = r_eval && hdr_match &&
                  ((r_state == S_HUNT) || w_last);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_HUNT;
         r_eval    <= 1'b0;
         r_capture <= 1'b0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
         r_drop    <= '0;
         r_sync    <= '0;
         r_bit_cnt <= '0;
         r_idle    <= '0;
      end else begin
         r_eval    <= bit_tick;
         r_capture <= 1'b0;
         r_overrun <= 1'b0;

         if (bit_tick)
            r_idle <= '0;
         else if (r_idle != IDLE_W'(TIMEOUT_CLKS))
            r_idle <= r_idle + IDLE_W'(1);

         if (w_bnd) begin
            r_state   <= S_LOCKED;
            r_bit_cnt <= '0;
            if (!r_valid || pkt_ready) begin
               r_capture <= 1'b1;
               r_valid   <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
               if (r_drop != '1)
                  r_drop <= r_drop + STAT_W'(1);
            end
         end else begin
            if (w_xfer)
               r_valid <= 1'b0;
            if (r_state == S_LOCKED) begin
               if (w_timeout || (r_eval && w_last)) begin
                  r_state   <= S_HUNT;
                  r_bit_cnt <= '0;
                  if (r_sync != '1)
                     r_sync <= r_sync + STAT_W'(1);
               end else if (r_eval) begin
                  r_bit_cnt <= r_bit_cnt + CNT_W'(1);
               end
            end
         end
      end
   end

   assign capture         = r_capture;
   assign pkt_valid       = r_valid;
   assign locked          = (r_state == S_LOCKED);
   assign overrun         = r_overrun;
   assign drop_count      = r_drop;
   assign sync_loss_count = r_sync;
   assign bit_cnt         = r_bit_cnt;

endmodule

// File: tb/tb_lidar_packet_ctrl.sv
// Directed bench for lidar_packet_ctrl: lock, false headers, sync loss,
// overrun, coincident handshake, timeout and reset.
module tb_lidar_packet_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       bit_tick;
   logic       hdr_match;
   logic       pkt_ready;
   logic       capture;
   logic       pkt_valid;
   logic       locked;
   logic       overrun;
   logic [7:0] drop_count;
   logic [7:0] sync_loss_count;
   logic [8:0] bit_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   lidar_packet_ctrl dut (
      .clk             (clk),
      .reset           (reset),
      .bit_tick        (bit_tick),
      .hdr_match       (hdr_match),
      .pkt_ready       (pkt_ready),
      .capture         (capture),
      .pkt_valid       (pkt_valid),
      .locked          (locked),
      .overrun         (overrun),
      .drop_count      (drop_count),
      .sync_loss_count (sync_loss_count),
      .bit_cnt         (bit_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One bit: tick, then eval cycle (ready driven there), then sample
   task automatic send_bit(input logic h, input logic r);
      @(negedge clk);
      bit_tick  = 1'b1;
      hdr_match = h;
      @(negedge clk);
      bit_tick  = 1'b0;
      pkt_ready = r;
      @(negedge clk);
      pkt_ready = 1'b0;
      hdr_match = 1'b0;
   endtask

   task automatic bits(input int n);
      for (int i = 0; i < n; i++)
         send_bit(1'b0, 1'b0);
   endtask

   initial begin
      reset     = 1'b1;
      bit_tick  = 1'b0;
      hdr_match = 1'b0;
      pkt_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_locked", locked, 0);
      chk("rst_valid", pkt_valid, 0);
      chk("rst_capture", capture, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_drop", drop_count, 0);
      chk("rst_sync", sync_loss_count, 0);
      chk("rst_bitcnt", bit_cnt, 0);
      reset = 1'b0;

      // First header in HUNT locks and captures
      send_bit(1'b1, 1'b0);
      chk("lock_locked", locked, 1);
      chk("lock_capture", capture, 1);
      chk("lock_valid", pkt_valid, 1);
      chk("lock_bitcnt", bit_cnt, 0);
      @(negedge clk);
      chk("lock_cap_pulse", capture, 0);
      pkt_ready = 1'b1;
      @(negedge clk);
      pkt_ready = 1'b0;
      chk("xfer_valid", pkt_valid, 0);

      // False header inside payload
      bits(100);
      chk("pre_false_cnt", bit_cnt, 100);
      send_bit(1'b1, 1'b0);
      chk("false_locked", locked, 1);
      chk("false_capture", capture, 0);
      chk("false_bitcnt", bit_cnt, 101);
      bits(274);
      chk("pre_bnd_cnt", bit_cnt, 375);

      // Boundary at eval #377, ready high
      send_bit(1'b1, 1'b1);
      chk("bnd2_capture", capture, 1);
      chk("bnd2_valid", pkt_valid, 1);
      chk("bnd2_bitcnt", bit_cnt, 0);
      chk("bnd2_drop", drop_count, 0);

      // Boundary while held packet not consumed
      bits(375);
      send_bit(1'b1, 1'b0);
      chk("ovr_pulse", overrun, 1);
      chk("ovr_capture", capture, 0);
      chk("ovr_valid", pkt_valid, 1);
      chk("ovr_drop", drop_count, 1);
      chk("ovr_locked", locked, 1);
      @(negedge clk);
      chk("ovr_once", overrun, 0);
      chk("ovr_valid2", pkt_valid, 1);

      // Ready coincident with boundary: valid stays high
      bits(375);
      chk("coin_pre_valid", pkt_valid, 1);
      send_bit(1'b1, 1'b1);
      chk("coin_capture", capture, 1);
      chk("coin_valid", pkt_valid, 1);
      chk("coin_drop", drop_count, 1);
      chk("coin_overrun", overrun, 0);

      // Missing header at expected boundary
      bits(375);
      send_bit(1'b0, 1'b0);
      chk("slip_locked", locked, 0);
      chk("slip_sync", sync_loss_count, 1);
      chk("slip_bitcnt", bit_cnt, 0);
      chk("slip_capture", capture, 0);
      chk("slip_valid", pkt_valid, 1);

      // Relock with busy holder, then bit_tick timeout
      send_bit(1'b1, 1'b0);
      chk("relock_locked", locked, 1);
      chk("relock_drop", drop_count, 2);
      bits(10);
      chk("to_pre_cnt", bit_cnt, 10);
      repeat (4200) @(negedge clk);
      chk("to_locked", locked, 0);
      chk("to_sync", sync_loss_count, 2);
      chk("to_bitcnt", bit_cnt, 0);
      chk("to_valid", pkt_valid, 1);

      // Reset mid-packet with a held packet
      send_bit(1'b1, 1'b0);
      bits(5);
      chk("prerst_cnt", bit_cnt, 5);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mrst_valid", pkt_valid, 0);
      chk("mrst_locked", locked, 0);
      chk("mrst_drop", drop_count, 0);
      chk("mrst_sync", sync_loss_count, 0);
      chk("mrst_bitcnt", bit_cnt, 0);
      chk("mrst_capture", capture, 0);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
